// File: rtl/sum_buf_pkg.sv
// Shared widths and constants for the adder result buffer.
// The top level and the storage array both take their default sizes from here.
package sum_buf_pkg;

  localparam int DATA_W = 32;
  localparam int SUM_W  = DATA_W + 1;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

endpackage : sum_buf_pkg

// File: rtl/sum_fifo_mem.sv
// Storage array for the result FIFO: one synchronous write port and one
// combinational read port, so the head entry is visible without extra latency.
module sum_fifo_mem
  import sum_buf_pkg::*;
#(
  parameter int WIDTH   = SUM_W,
  parameter int ENTRIES = DEPTH,
  parameter int AW      = PTR_W
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [ENTRIES];

  // Contents are never reset; occupancy tracking in the parent decides validity.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : sum_fifo_mem

// File: rtl/sum_result_buffer.sv
// Result buffer behind the bypass adder: FWFT FIFO with valid/ready on both
// sides, a saturating carry-event counter and a sticky overflow-drop flag.
module sum_result_buffer #(
  parameter int DATA_W = sum_buf_pkg::DATA_W,
  parameter int DEPTH  = sum_buf_pkg::DEPTH,
  parameter int CNT_W  = sum_buf_pkg::CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_W:0]          in_sum,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W:0]          out_sum,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         carry_cnt,
  output logic                     drop_err,
  input  logic                     clr
);

  localparam int SUM_W = DATA_W + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;
  logic             drop_err_q, drop_err_d;
  logic [SUM_W-1:0] rd_data;
  logic             push, pop;

  // Ready depends only on stored occupancy, never on out_ready.
  assign in_ready  = (level_q != LVL_FULL);
  assign out_valid = (level_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  sum_fifo_mem #(
    .WIDTH  (SUM_W),
    .ENTRIES(DEPTH),
    .AW     (PTR_W)
  ) u_mem (
    .clk    (clk),
    .we_i   (push),
    .waddr_i(wr_ptr_q),
    .wdata_i(in_sum),
    .raddr_i(rd_ptr_q),
    .rdata_o(rd_data)
  );

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    level_d     = level_q;
    carry_cnt_d = carry_cnt_q;
    drop_err_d  = drop_err_q;

    // DEPTH is a power of two, so the pointers wrap naturally.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // clr takes priority over a coincident increment or drop.
    if (clr) begin
      carry_cnt_d = '0;
      drop_err_d  = 1'b0;
    end else begin
      if (push && in_sum[DATA_W] && (carry_cnt_q != CNT_SAT)) begin
        carry_cnt_d = carry_cnt_q + CNT_W'(1);
      end
      if (in_valid && !in_ready) begin
        drop_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      carry_cnt_q <= '0;
      drop_err_q  <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      carry_cnt_q <= carry_cnt_d;
      drop_err_q  <= drop_err_d;
    end
  end

  assign out_sum   = out_valid ? rd_data : '0;
  assign level     = level_q;
  assign carry_cnt = carry_cnt_q;
  assign drop_err  = drop_err_q;

endmodule : sum_result_buffer

// File: tb/tb_sum_result_buffer.sv
// Bench for sum_result_buffer (4-bit counter build): directed scenarios plus a
// random phase, every cycle compared against a queue-based reference model.
module tb_sum_result_buffer;

  localparam int DW    = 32;
  localparam int SW    = DW + 1;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [SW-1:0] in_sum = '0;
  logic          in_ready;
  logic          out_valid;
  logic [SW-1:0] out_sum;
  logic          out_ready = 1'b0;
  logic [LW-1:0] level;
  logic [CW-1:0] carry_cnt;
  logic          drop_err;
  logic          clr = 1'b0;

  sum_result_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_sum   (in_sum),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_sum  (out_sum),
    .out_ready(out_ready),
    .level    (level),
    .carry_cnt(carry_cnt),
    .drop_err (drop_err),
    .clr      (clr)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of accepted sums, a counter and a flag.
  logic [SW-1:0] mq[$];
  int            mcnt;
  bit            mdrop;
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    logic [SW-1:0] head;
    head = (mq.size() != 0) ? mq[0] : '0;
    chk({ctx, ".out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
    chk({ctx, ".out_sum"},   64'(out_sum),   64'(head));
    chk({ctx, ".level"},     64'(level),     64'(mq.size()));
    chk({ctx, ".in_ready"},  64'(in_ready),  64'(mq.size() != DEPTH));
    chk({ctx, ".carry_cnt"}, 64'(carry_cnt), 64'(mcnt));
    chk({ctx, ".drop_err"},  64'(drop_err),  64'(mdrop));
  endtask

  // One clock: drive inputs, let the edge pass, update model, compare.
  task automatic cycle(input string ctx, input logic v, input logic [SW-1:0] d,
                       input logic r, input logic c);
    bit full, empty, push, pop;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    push  = v && !full;
    pop   = r && !empty;
    in_valid  = v;
    in_sum    = v ? d : SW'($urandom);
    out_ready = r;
    clr       = c;
    @(posedge clk);
    #1;
    if (pop) begin
      $display("[%0t] %s pop %h", $time, ctx, mq[0]);
      void'(mq.pop_front());
    end
    if (push) begin
      $display("[%0t] %s push %h", $time, ctx, d);
      mq.push_back(d);
    end
    if (c) begin
      mcnt  = 0;
      mdrop = 0;
    end else begin
      if (push && d[DW] && mcnt < CMAX) mcnt++;
      if (v && full) mdrop = 1;
    end
    check_all(ctx);
  endtask

  logic [SW-1:0] vec[4];
  logic [SW-1:0] rnd;

  initial begin
    mcnt  = 0;
    mdrop = 0;
    vec[0] = 33'h1_0000_0000;
    vec[1] = 33'h0_FFFF_FFFF;
    vec[2] = 33'h1_0000_0001;
    vec[3] = 33'h0_0000_0000;

    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single push then pop.
    cycle("single", 1'b1, 33'h0_0000_0005, 1'b0, 1'b0);
    cycle("single", 1'b0, '0, 1'b1, 1'b0);
    cycle("idle_pop", 1'b0, '0, 1'b1, 1'b0);

    // Fill, overflow, drain.
    for (int i = 0; i < 4; i++) cycle("fill", 1'b1, vec[i], 1'b0, 1'b0);
    cycle("overflow", 1'b1, 33'h1_2345_6789, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0);

    // Steady state at level 2 with simultaneous push and pop.
    cycle("prime", 1'b1, 33'h0_0000_00A0, 1'b0, 1'b0);
    cycle("prime", 1'b1, 33'h0_0000_00A1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      cycle("stream", 1'b1, SW'(32'hB000_0000 + i), 1'b1, 1'b0);

    // Full with both sides active: pop only, then push accepted next cycle.
    cycle("tofull", 1'b1, 33'h0_0000_00C0, 1'b0, 1'b0);
    cycle("tofull", 1'b1, 33'h0_0000_00C1, 1'b0, 1'b0);
    cycle("full_both", 1'b1, 33'h1_0000_00C2, 1'b1, 1'b0);
    cycle("after_full", 1'b1, 33'h1_0000_00C3, 1'b1, 1'b0);

    // Saturate the carry counter, then clr against a carry push.
    for (int i = 0; i < 20; i++)
      cycle("sat", 1'b1, {1'b1, 32'($urandom)}, 1'b1, 1'b0);
    cycle("clr", 1'b1, {1'b1, 32'($urandom)}, 1'b1, 1'b1);
    cycle("post_clr", 1'b0, '0, 1'b1, 1'b0);

    // Reset in the middle of traffic at level 3.
    while (mq.size() > 0) cycle("empty", 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, SW'(32'hD0 + i), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    mq.delete();
    mcnt  = 0;
    mdrop = 0;
    check_all("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_rst", 1'b1, 33'h1_0000_0EEE, 1'b0, 1'b0);
    cycle("post_rst", 1'b0, '0, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      rnd = {1'($urandom), 32'($urandom)};
      cycle("rand", 1'($urandom), rnd, 1'($urandom), ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sum_result_buffer
